// File: rtl/arb_pkg.sv
// Shared defaults and state type for the bypass arbiter.
package arb_pkg;

    localparam int unsigned ARB_N         = 3;
    localparam int unsigned ARB_WIDTH     = 8;
    localparam int unsigned ARB_MAX_BURST = 4;

    // IDLE: no grant outstanding. OWNED: exactly one port holds the grant.
    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request at or after ptr_i, with wrap-around.
module rr_picker #(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          found_o
);

    logic [PW-1:0] idx;

    // Walk the ports starting at the pointer; the first requester wins.
    always_comb begin
        gnt_o   = '0;
        found_o = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr_i) + i) % N);
            if (!found_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bypass_arbiter.sv
// Round-robin grant arbiter merging N bypass FIFOs into one registered stream.
// Optional feature: define ARB_BURST_LIMIT_EN to force grant rotation after MAX_BURST
// accepted beats when another port is waiting.
module bypass_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N         = ARB_N,
    parameter int unsigned WIDTH     = ARB_WIDTH,
    parameter int unsigned MAX_BURST = ARB_MAX_BURST,
    localparam int unsigned OW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [N-1:0]       i_Req,
    input  logic [N-1:0]       i_Valid,
    input  logic [N*WIDTH-1:0] i_Data,
    output logic [N-1:0]       o_Grant,
    output logic [N-1:0]       o_Busy,
    output logic               o_Valid,
    output logic [WIDTH-1:0]   o_Data,
    output logic [OW-1:0]      o_Owner
);

    arb_state_e       state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

`ifdef ARB_BURST_LIMIT_EN
    localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    logic [CW-1:0]    cnt_q, cnt_d;
`endif

    logic [N-1:0]     pick_req;
    logic [N-1:0]     pick_gnt;
    logic             pick_found;
    logic [OW-1:0]    pick_idx;
    logic [OW-1:0]    pick_next;
    logic             owner_req;
    logic             beat;
    logic [WIDTH-1:0] beat_data;
    logic             take;

    // The owner is masked out so the same picker serves idle grant, hand-over and rotation.
    assign pick_req = i_Req & ~grant_q;

    rr_picker #(
        .N  (N),
        .PW (OW)
    ) u_picker (
        .req_i   (pick_req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .found_o (pick_found)
    );

    // Convert the picker's one-hot grant to an index.
    always_comb begin
        pick_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (pick_gnt[k]) begin
                pick_idx = OW'(k);
            end
        end
    end

    assign pick_next = (pick_idx == OW'(N - 1)) ? '0 : pick_idx + 1'b1;
    assign owner_req = |(i_Req & grant_q);
    assign beat      = |(i_Valid & grant_q);

    // Select the granted port's data; other ports' data never reaches the output.
    always_comb begin
        beat_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (grant_q[k]) begin
                beat_data = i_Data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: grant on request, hand over when the owner drops, optional burst rotation.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        valid_d  = beat;
        data_d   = beat ? beat_data : data_q;
        take     = 1'b0;
`ifdef ARB_BURST_LIMIT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                take = pick_found;
            end
            OWNED: begin
                if (!owner_req) begin
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
`ifdef ARB_BURST_LIMIT_EN
                else if (beat) begin
                    if (cnt_q == CW'(MAX_BURST - 1)) begin
                        // Burst exhausted: rotate if someone waits, else restart the count.
                        take  = pick_found;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (take) begin
            state_d  = OWNED;
            grant_d  = pick_gnt;
            owner_d  = pick_idx;
            rr_ptr_d = pick_next;
        end
`ifdef ARB_BURST_LIMIT_EN
        if (take || state_d == IDLE) begin
            cnt_d = '0;
        end
`endif
    end

    // FSM and registered outputs; reset drops the grant and any beat in flight.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
`ifdef ARB_BURST_LIMIT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
`ifdef ARB_BURST_LIMIT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign o_Grant = grant_q;
    assign o_Busy  = (grant_q != '0) ? ~grant_q : '0;
    assign o_Valid = valid_q;
    assign o_Data  = data_q;
    assign o_Owner = owner_q;

endmodule

// File: doc/bypass_arbiter.md
BYPASS_ARBITER -- requirements
Module: bypass_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 3, giving the number of requesting bypass FIFOs.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the data width per port.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, giving the beats per grant before forced rotation (used only under ARB_BURST_LIMIT_EN).
REQ-004 The block SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port i_Req  input  N  per-port grant request, driven by each FIFO's o_Grant.
REQ-007 The block SHALL have port i_Valid  input  N  per-port data valid, driven by each FIFO's o_Valid.
REQ-008 The block SHALL have port i_Data  input  N*WIDTH  packed per-port data; port k occupies bits [k*WIDTH +: WIDTH].
REQ-009 The block SHALL have port o_Grant  output  N  registered one-hot-or-zero grant, wired to each FIFO's i_Grant.
REQ-010 The block SHALL have port o_Busy  output  N  bit k high when a port other than k holds the grant, so FIFO k must buffer instead of bypassing.
REQ-011 The block SHALL have port o_Valid  output  1  registered merged-stream valid.
REQ-012 The block SHALL have port o_Data  output  WIDTH  registered merged-stream data.
REQ-013 The block SHALL have port o_Owner  output  $clog2(N)  index of the current grant holder; meaningful only while |o_Grant.

Function
REQ-014 The FSM SHALL have two states: IDLE (o_Grant==0) and OWNED (exactly one o_Grant bit set).
REQ-015 In IDLE, if i_Req!=0 at an edge, the FSM SHALL grant the first requester at or after rr_ptr, scanning upward with wrap-around, and enter OWNED at that edge.
REQ-016 In OWNED, if i_Req[owner]==0 at an edge, the grant SHALL pass at that edge to the next requester after owner (round-robin), or the FSM SHALL return to IDLE if no port requests.
REQ-017 On every grant change, rr_ptr SHALL become (new owner + 1) mod N, so no port is granted twice while another waits.
REQ-018 A beat SHALL be accepted when i_Valid[owner] && o_Grant[owner]; o_Valid/o_Data SHALL show it one cycle later (latency 1).
REQ-019 i_Valid on non-granted ports SHALL be ignored and SHALL never appear on o_Data.
REQ-020 o_Busy SHALL equal (o_Grant != 0) ? ~o_Grant : 0.
REQ-021 Simultaneous requests from all ports at reset exit SHALL be granted in order 0,1,2,0,...
REQ-022 Owner-request deassertion and a new request in the same cycle SHALL resolve with no idle cycle between grants.

Reset
REQ-023 While Reset==0, o_Grant, o_Busy, o_Valid, o_Data, o_Owner, rr_ptr and the burst counter SHALL be 0 and the FSM SHALL be in IDLE, asynchronously.
REQ-024 Reset asserted mid-burst SHALL drop o_Grant immediately; any beat in flight SHALL be discarded.

Configuration
REQ-025 With ARB_BURST_LIMIT_EN defined, a counter SHALL count accepted beats; on the MAX_BURST-th beat, if any other port requests, the grant SHALL rotate at that edge; otherwise the owner SHALL keep the grant and the counter SHALL clear.
REQ-026 Without ARB_BURST_LIMIT_EN, no counter SHALL exist and the grant SHALL be held until the owner drops i_Req.
REQ-027 The burst counter SHALL clear on every grant change.

Structure
REQ-028 Package arb_pkg SHALL hold the default N, WIDTH and MAX_BURST constants and the state typedef (IDLE, OWNED).
REQ-029 Sub-module rr_picker SHALL implement the combinational round-robin select (inputs: request vector, rr_ptr; outputs: one-hot grant, found flag).

Verification
REQ-030 Single requester: i_Req=001 with port 0 beats 1,2,3,4 -> o_Grant=001; o_Data 1,2,3,4 one cycle after each beat; o_Busy=110.
REQ-031 Contention: i_Req=011 from reset with port 0 holding -> port 1 waits; o_Busy[1]=1; port 0 drops i_Req -> o_Grant=010 at the next edge, with no gap.
REQ-032 Burst limit (macro on): ports 0 and 2 request continuously -> grant alternates every 4 accepted beats; with the macro off, port 0 keeps the grant indefinitely.
REQ-033 Fairness: i_Req=111 held, each owner drops i_Req after one beat -> grant sequence 001, 010, 100, 001.
REQ-034 Isolation: i_Valid=110 with o_Grant=001 -> o_Valid stays 0.
REQ-035 Reset: Reset driven low mid-burst -> o_Grant=0 and o_Valid=0 immediately; after release, arbitration restarts at port 0.
